// File: rtl/sys_cmd_host.sv
`default_nettype none
// ============================================================================
// Module   : sys_cmd_host
// Brief    : Host-side command initiator; frames one command onto a UART TX
//            byte stream and assembles the response bytes from UART RX.
// Revision : 1.0 - initial release
// ============================================================================
module sys_cmd_host #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int ALU_FUN_WIDTH  = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int TO_WIDTH       = 16
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic [1:0]               i_cmd_type,
   input  logic [ADDR_WIDTH-1:0]    i_addr,
   input  logic [DATA_WIDTH-1:0]    i_wr_data,
   input  logic [DATA_WIDTH-1:0]    i_op_a,
   input  logic [DATA_WIDTH-1:0]    i_op_b,
   input  logic [ALU_FUN_WIDTH-1:0] i_alu_fun,
   output logic [DATA_WIDTH-1:0]    o_tx_data,
   output logic                     o_tx_valid,
   input  logic                     i_tx_ready,
   input  logic [DATA_WIDTH-1:0]    i_rx_data,
   input  logic                     i_rx_valid,
   output logic [2*DATA_WIDTH-1:0]  o_rsp_data,
   output logic                     o_rsp_valid,
   output logic                     o_timeout,
   output logic                     o_busy
);
   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_SEND = 2'd1;
   localparam logic [1:0] c_S_WAIT = 2'd2;

   localparam logic [1:0] c_T_WR     = 2'd0;
   localparam logic [1:0] c_T_RD     = 2'd1;
   localparam logic [1:0] c_T_ALU_OP = 2'd2;

   localparam logic [DATA_WIDTH-1:0] c_HDR_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] c_HDR_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] c_HDR_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] c_HDR_ALU    = DATA_WIDTH'(8'hDD);
   localparam logic [TO_WIDTH-1:0]   c_TO_LAST    = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]               state_q, state_d;
   logic [1:0]               type_q, type_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wr_q, wr_d, op_a_q, op_a_d, op_b_q, op_b_d;
   logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;
   logic [1:0]               idx_q, idx_d;
   logic                     rsp_cnt_q, rsp_cnt_d;
   logic [TO_WIDTH-1:0]      to_cnt_q, to_cnt_d;
   logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
   logic                     tx_valid_q, tx_valid_d;
   logic [2*DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic                     timeout_q, timeout_d;

   logic                     w_accept, w_tx_fire, w_last_byte, w_rsp_last, w_to_hit;
   logic [1:0]               w_last_idx;

   function automatic logic [DATA_WIDTH-1:0] frame_byte(
      input logic [1:0]               typ,
      input logic [1:0]               idx,
      input logic [ADDR_WIDTH-1:0]    addr,
      input logic [DATA_WIDTH-1:0]    wr_data,
      input logic [DATA_WIDTH-1:0]    op_a,
      input logic [DATA_WIDTH-1:0]    op_b,
      input logic [ALU_FUN_WIDTH-1:0] fun
   );
      logic [DATA_WIDTH-1:0] addr_x;
      logic [DATA_WIDTH-1:0] fun_x;
      addr_x = DATA_WIDTH'(addr);
      fun_x  = DATA_WIDTH'(fun);
      case (typ)
         c_T_WR:     frame_byte = (idx == 2'd0) ? c_HDR_WR : (idx == 2'd1) ? addr_x : wr_data;
         c_T_RD:     frame_byte = (idx == 2'd0) ? c_HDR_RD : addr_x;
         c_T_ALU_OP: frame_byte = (idx == 2'd0) ? c_HDR_ALU_OP : (idx == 2'd1) ? op_a :
                                  (idx == 2'd2) ? op_b : fun_x;
         default:    frame_byte = (idx == 2'd0) ? c_HDR_ALU : fun_x;
      endcase
   endfunction

   always_comb begin
      case (type_q)
         c_T_WR:     w_last_idx = 2'd2;
         c_T_ALU_OP: w_last_idx = 2'd3;
         default:    w_last_idx = 2'd1;
      endcase
   end

   assign w_accept    = i_cmd_valid && (state_q == c_S_IDLE);
   assign w_tx_fire   = (state_q == c_S_SEND) && tx_valid_q && i_tx_ready;
   assign w_last_byte = w_tx_fire && (idx_q == w_last_idx);
   assign w_rsp_last  = i_rx_valid && ((type_q == c_T_RD) || rsp_cnt_q);
   // A byte arriving on the terminal count takes priority over the timeout.
   assign w_to_hit    = !i_rx_valid && (to_cnt_q == c_TO_LAST);

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q     <= c_S_IDLE;
         type_q      <= '0;
         addr_q      <= '0;
         wr_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         fun_q       <= '0;
         idx_q       <= '0;
         rsp_cnt_q   <= 1'b0;
         to_cnt_q    <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         fun_q       <= fun_d;
         idx_q       <= idx_d;
         rsp_cnt_q   <= rsp_cnt_d;
         to_cnt_q    <= to_cnt_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_S_IDLE: if (w_accept) state_d = c_S_SEND;
         c_S_SEND: if (w_last_byte) state_d = (type_q == c_T_WR) ? c_S_IDLE : c_S_WAIT;
         c_S_WAIT: if (w_rsp_last || w_to_hit) state_d = c_S_IDLE;
         default:  state_d = c_S_IDLE;
      endcase
   end

   always_comb begin
      type_d      = type_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      fun_d       = fun_q;
      idx_d       = idx_q;
      rsp_cnt_d   = rsp_cnt_q;
      to_cnt_d    = to_cnt_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         c_S_IDLE: begin
            if (w_accept) begin
               type_d     = i_cmd_type;
               addr_d     = i_addr;
               wr_d       = i_wr_data;
               op_a_d     = i_op_a;
               op_b_d     = i_op_b;
               fun_d      = i_alu_fun;
               idx_d      = 2'd0;
               tx_valid_d = 1'b1;
               tx_data_d  = frame_byte(i_cmd_type, 2'd0, i_addr, i_wr_data,
                                       i_op_a, i_op_b, i_alu_fun);
            end
         end
         c_S_SEND: begin
            if (w_last_byte) begin
               tx_valid_d = 1'b0;
               rsp_cnt_d  = 1'b0;
               to_cnt_d   = '0;
               if (type_q == c_T_WR) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
               end
            end else if (w_tx_fire) begin
               idx_d     = idx_q + 2'd1;
               tx_data_d = frame_byte(type_q, idx_q + 2'd1, addr_q, wr_q, op_a_q, op_b_q, fun_q);
            end
         end
         c_S_WAIT: begin
            if (i_rx_valid) begin
               to_cnt_d  = '0;
               rsp_cnt_d = 1'b1;
               if (rsp_cnt_q) begin
                  rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = i_rx_data;
               end else begin
                  rsp_data_d[DATA_WIDTH-1:0] = i_rx_data;
                  if (type_q == c_T_RD) rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = '0;
               end
               rsp_valid_d = w_rsp_last;
            end else if (w_to_hit) begin
               timeout_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   assign o_cmd_ready = (state_q == c_S_IDLE);
   assign o_busy      = (state_q != c_S_IDLE);
   assign o_tx_data   = tx_data_q;
   assign o_tx_valid  = tx_valid_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_cmd_host
// Brief    : Directed self-checking bench for sys_cmd_host (TIMEOUT_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_cmd_host;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic [3:0]  addr;
   logic [7:0]  wr_data, op_a, op_b;
   logic [3:0]  alu_fun;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [15:0] rsp_data;
   logic        rsp_valid, timeout, busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sys_cmd_host #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4),
      .TIMEOUT_CYCLES(16), .TO_WIDTH(16)
   ) dut (
      .i_CLK(clk), .i_RST(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_type(cmd_type),
      .i_addr(addr), .i_wr_data(wr_data), .i_op_a(op_a), .i_op_b(op_b),
      .i_alu_fun(alu_fun),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_rsp_data(rsp_data), .o_rsp_valid(rsp_valid), .o_timeout(timeout),
      .o_busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive and sample 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] w,
                        input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
      cmd_valid = 1'b1; cmd_type = t; addr = a; wr_data = w; op_a = oa; op_b = ob; alu_fun = f;
      tick();
      // Scramble inputs: captured fields must not follow them.
      cmd_valid = 1'b0; cmd_type = ~t; addr = ~a; wr_data = ~w; op_a = ~oa; op_b = ~ob; alu_fun = ~f;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] rdy_pat;
      logic       seen;

      rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; addr = '0; wr_data = '0;
      op_a = '0; op_b = '0; alu_fun = '0; tx_ready = 1'b1; rx_data = '0; rx_valid = 1'b0;
      tick(); tick();
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      // Register write: AA,05,3C back-to-back, immediate completion.
      issue(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
      chk("wr_b0_valid", tx_valid, 1);
      chk("wr_b0", tx_data, 8'hAA);
      chk("wr_busy", busy, 1);
      chk("wr_ready", cmd_ready, 0);
      tick(); chk("wr_b1", tx_data, 8'h05);
      tick(); chk("wr_b2", tx_data, 8'h3C);
      chk("wr_b2_valid", tx_valid, 1);
      tick();
      chk("wr_done_tx_valid", tx_valid, 0);
      chk("wr_rsp_valid", rsp_valid, 1);
      chk("wr_rsp_data", rsp_data, 16'h0000);
      chk("wr_done_ready", cmd_ready, 1);
      tick(); chk("wr_rsp_pulse_end", rsp_valid, 0);

      // Register read: BB,02 then one response byte.
      issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
      chk("rd_b0", tx_data, 8'hBB);
      tick(); chk("rd_b1", tx_data, 8'h02);
      tick();
      chk("rd_wait_tx_valid", tx_valid, 0);
      chk("rd_wait_busy", busy, 1);
      rx_data = 8'h7E; rx_valid = 1'b1;
      tick(); rx_valid = 1'b0;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_data", rsp_data, 16'h007E);
      chk("rd_ready", cmd_ready, 1);
      tick(); chk("rd_rsp_pulse_end", rsp_valid, 0);

      // ALU with operands: CC,0A,14,00; two response bytes with a gap.
      issue(2'd2, 4'h0, 8'h00, 8'h0A, 8'h14, 4'h0);
      chk("alu_b0", tx_data, 8'hCC);
      tick(); chk("alu_b1", tx_data, 8'h0A);
      tick(); chk("alu_b2", tx_data, 8'h14);
      tick(); chk("alu_b3", tx_data, 8'h00);
      tick(); chk("alu_wait_tx_valid", tx_valid, 0);
      rx_data = 8'h1E; rx_valid = 1'b1;
      tick(); rx_valid = 1'b0;
      chk("alu_partial_valid", rsp_valid, 0);
      chk("alu_partial_lo", rsp_data[7:0], 8'h1E);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | rsp_valid | timeout;
      end
      chk("alu_gap_quiet", seen, 0);
      rx_data = 8'h00; rx_valid = 1'b1;
      tick(); rx_valid = 1'b0;
      chk("alu_rsp_valid", rsp_valid, 1);
      chk("alu_rsp_data", rsp_data, 16'h001E);
      tick(); chk("alu_rsp_pulse_end", rsp_valid, 0);

      // ALU without operands under TX backpressure 0,0,1,0,1.
      rdy_pat = 5'b10100;
      tx_ready = 1'b0;
      issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
      for (int i = 0; i < 5; i++) begin
         tx_ready = rdy_pat[i];
         chk("bp_valid", tx_valid, 1);
         chk("bp_data", tx_data, (i < 3) ? 8'hDD : 8'h02);
         tick();
      end
      tx_ready = 1'b1;
      chk("bp_done_tx_valid", tx_valid, 0);
      rx_data = 8'h34; rx_valid = 1'b1; tick();
      rx_data = 8'h12; tick(); rx_valid = 1'b0;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 16'h1234);
      tick();

      // Read with no response: timeout 16 cycles after entering WAIT_RSP.
      issue(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
      tick(); tick();
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         seen = seen | timeout | rsp_valid | ~busy;
      end
      chk("to_early", seen, 0);
      tick();
      chk("to_pulse", timeout, 1);
      chk("to_rsp_valid", rsp_valid, 0);
      chk("to_ready", cmd_ready, 1);
      chk("to_rsp_kept", rsp_data, 16'h1234);
      tick();
      chk("to_pulse_end", timeout, 0);
      chk("to_ready_next", cmd_ready, 1);

      // Byte arriving on the terminal count completes normally.
      issue(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
      tick(); tick();
      for (int i = 0; i < 15; i++) tick();
      rx_data = 8'h5A; rx_valid = 1'b1;
      tick(); rx_valid = 1'b0;
      chk("term_timeout", timeout, 0);
      chk("term_rsp_valid", rsp_valid, 1);
      chk("term_rsp_data", rsp_data, 16'h005A);
      tick(); chk("term_after_timeout", timeout, 0);

      // Reset after the second byte of an ALU frame.
      issue(2'd2, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3);
      tick(); tick();
      chk("mid_b2", tx_data, 8'h22);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("mid_tx_valid", tx_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_ready", cmd_ready, 1);
      rx_data = 8'h99; rx_valid = 1'b1;
      tick(); rx_valid = 1'b0;
      chk("stray_rsp_valid", rsp_valid, 0);
      tick();
      chk("stray_rsp_valid2", rsp_valid, 0);
      chk("stray_rsp_data", rsp_data, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sys_cmd_host.md
Name: sys_cmd_host

Overview:
- Host-side command initiator; the peer of the system controller's UART command protocol.
- Accepts one command at a time on a valid/ready request port.
- Serializes the command into the frame bytes the system controller expects, and drives them to a UART TX byte interface.
- Collects response bytes from a UART RX byte interface, then returns the assembled result or reports a timeout.
- Used in host-emulation benches and in a loopback bring-up top.

Parameters:
- DATA_WIDTH, 8, width of a frame byte and of register/operand data.
- ADDR_WIDTH, 4, register-file address width; zero-extended to DATA_WIDTH in the frame.
- ALU_FUN_WIDTH, 4, ALU function code width; zero-extended to DATA_WIDTH in the frame.
- TIMEOUT_CYCLES, 65535, maximum idle cycles allowed between response bytes.
- TO_WIDTH, 16, timeout counter width; TIMEOUT_CYCLES must be ≤ 2^TO_WIDTH−1.

Ports:
- i_CLK  in  1  system clock.
- i_RST  in  1  reset; synchronous, active-high.
- i_cmd_valid  in  1  command request valid.
- o_cmd_ready  out  1  block can accept a command; equals state==IDLE.
- i_cmd_type  in  2  command type: 0=RF write, 1=RF read, 2=ALU with operands, 3=ALU without operands.
- i_addr  in  ADDR_WIDTH  register address (types 0 and 1).
- i_wr_data  in  DATA_WIDTH  write data (type 0).
- i_op_a  in  DATA_WIDTH  operand A (type 2).
- i_op_b  in  DATA_WIDTH  operand B (type 2).
- i_alu_fun  in  ALU_FUN_WIDTH  ALU function (types 2 and 3).
- o_tx_data  out  DATA_WIDTH  frame byte to the UART TX.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  UART TX accepts the byte.
- i_rx_data  in  DATA_WIDTH  response byte from the UART RX.
- i_rx_valid  in  1  one-cycle strobe marking i_rx_data valid.
- o_rsp_data  out  2*DATA_WIDTH  assembled response.
- o_rsp_valid  out  1  one-cycle pulse when a command completes.
- o_timeout  out  1  one-cycle pulse when a response is abandoned.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (i_RST=1 at a rising edge): state=IDLE; o_tx_valid=0; o_tx_data=0; o_rsp_data=0; o_rsp_valid=0; o_timeout=0; byte index and timeout counter cleared. Reset applies from any state; an in-flight frame is abandoned and o_tx_valid is low in the cycle after reset.
- Frame formats, bytes in order:
  - Type 0: AA, addr, wr_data.
  - Type 1: BB, addr.
  - Type 2: CC, op_a, op_b, fun.
  - Type 3: DD, fun.
- Expected response length: type 0 → 0 bytes; type 1 → 1 byte; types 2 and 3 → 2 bytes, LSB first.
- States are IDLE, SEND, WAIT_RSP.
- IDLE: command accepted on an edge with i_cmd_valid && o_cmd_ready.
  - All command fields are captured into registers at that edge; later changes on the inputs have no effect.
  - Next state is SEND with byte index 0.
  - o_tx_valid=1 with the first byte in the next cycle (1-cycle latency).
- SEND: o_tx_data and o_tx_valid are registered and held stable while i_tx_ready=0.
  - On an edge with valid && ready, advance to the next byte. There are no idle cycles between bytes; back-to-back ready sends one byte per cycle.
  - After the last byte is accepted, o_tx_valid=0 in the next cycle.
    - Type 0: go to IDLE, pulse o_rsp_valid with o_rsp_data=0.
    - Otherwise: go to WAIT_RSP with the response byte count and timeout counter cleared.
- WAIT_RSP:
  - Each i_rx_valid stores the byte: first byte → o_rsp_data[DATA_WIDTH-1:0], second → upper half. The timeout counter is cleared on each byte.
  - Type 1: the upper half is forced to 0.
  - When the final expected byte is sampled: o_rsp_data is updated at that edge, o_rsp_valid=1 for exactly the next cycle, and state=IDLE. o_cmd_ready is high in that same cycle, so a new command is accepted concurrently.
  - Timeout: the counter increments each cycle without i_rx_valid. When it reaches TIMEOUT_CYCLES−1 with no i_rx_valid, pulse o_timeout for one cycle, go to IDLE, and leave o_rsp_valid low. o_rsp_data keeps any partial bytes.
  - If i_rx_valid coincides with the terminal count, the byte wins and no timeout occurs.
- i_rx_valid in IDLE or SEND is ignored; stray bytes are dropped.
- o_rsp_valid and o_timeout are never high in the same cycle.

Test Plan:
- Write: type 0, addr=5, data=3C, i_tx_ready=1 → tx bytes AA,05,3C on 3 consecutive cycles starting 1 cycle after accept; o_rsp_valid pulse with 0000; no RX needed.
- Read: type 1, addr=2; after frame BB,02, drive rx byte 7E → o_rsp_valid one cycle later, o_rsp_data=007E.
- ALU with operands: type 2, A=0A, B=14, fun=0 → frame CC,0A,14,00; rx 1E then 00 with 10 idle cycles between → o_rsp_data=001E, single pulse.
- Backpressure: type 3 fun=2 with i_tx_ready toggling 0,0,1,0,1 → DD accepted on the 3rd cycle, 02 on the 5th; o_tx_data never changes while unaccepted.
- Timeout: TIMEOUT_CYCLES=16, type 1 with no RX → o_timeout pulses exactly 16 cycles after WAIT_RSP entry, o_rsp_valid stays 0, o_cmd_ready=1 the next cycle; also check that rx_valid on the terminal cycle completes normally.
- Reset mid-frame: assert i_RST after the second byte of a type-2 frame → next cycle o_tx_valid=0, o_busy=0, o_cmd_ready=1; a stray rx byte afterwards produces no o_rsp_valid.
